// File: rtl/div_ctrl.sv
// Sequencing and sign fix-up wrapper around an unsigned divide core. It implements RISC-V M DIV/DIVU/REM/REMU.
// Latency: bypass cases (divide by zero, signed overflow) have out_valid one cycle after acceptance. Otherwise out_valid is one cycle after core_done.
// Backpressure: in_ready is high only in IDLE. A result is held in DONE until out_ready; flush aborts from any state.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           request handshake: in_op, in_rs1, in_rs2, in_rd
//   flush                       abort any in-flight operation
//   core_start                  level request to the core, with core_dividend/core_divisor
//   core_done                   core completion pulse, with core_quotient/core_remainder
//   out_valid/out_ready         result handshake: out_result, out_rd
//   busy                        high whenever the FSM is not idle
module div_ctrl #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [DW-1:0] in_rs1,
    input  logic [DW-1:0] in_rs2,
    input  logic [4:0]    in_rd,
    input  logic          flush,
    output logic          core_start,
    output logic [DW-1:0] core_dividend,
    output logic [DW-1:0] core_divisor,
    input  logic          core_done,
    input  logic [DW-1:0] core_quotient,
    input  logic [DW-1:0] core_remainder,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [4:0]    out_rd,
    output logic          busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

    state_t        state, state_nxt;

    logic [DW-1:0] mag_a, mag_b;     // unsigned magnitudes handed to the core
    logic          q_neg, r_neg;     // sign fix-up flags captured at acceptance
    logic          rem_sel;          // 1: return remainder, 0: return quotient
    logic [DW-1:0] result;
    logic [4:0]    rd_q;

    // Request decode. in_op[0]=0 means a signed op (DIV or REM), and in_op[1]=1 selects the remainder.
    logic          is_signed, rs1_neg, rs2_neg, div_zero, ovf, bypass, accept;
    logic [DW-1:0] bypass_res, q_fix, r_fix;

    always_comb begin
        is_signed = ~in_op[0];
        rs1_neg   = is_signed & in_rs1[DW-1];
        rs2_neg   = is_signed & in_rs2[DW-1];
        div_zero  = (in_rs2 == '0);
        ovf       = is_signed && (in_rs1 == MIN_NEG) && (in_rs2 == ALL_ONES);
        bypass    = div_zero | ovf;
        // Divide by zero takes precedence. The remainder is the raw dividend, even for signed ops.
        if (div_zero)
            bypass_res = in_op[1] ? in_rs1 : ALL_ONES;
        else
            bypass_res = in_op[1] ? '0 : MIN_NEG;
        // flush wins over a simultaneous request
        accept    = in_valid & in_ready & ~flush;
        q_fix     = q_neg ? -core_quotient  : core_quotient;
        r_fix     = r_neg ? -core_remainder : core_remainder;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept)     state_nxt = bypass ? ST_DONE : ST_WAIT;
                ST_WAIT: if (core_done)  state_nxt = ST_DONE;
                ST_DONE: if (out_ready)  state_nxt = ST_IDLE;
                default:                 state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs. Core operands are forced to zero whenever core_start is low.
    always_comb begin
        in_ready      = (state == ST_IDLE);
        busy          = (state != ST_IDLE);
        core_start    = (state == ST_WAIT);
        core_dividend = (state == ST_WAIT) ? mag_a : '0;
        core_divisor  = (state == ST_WAIT) ? mag_b : '0;
        out_valid     = (state == ST_DONE);
        out_result    = result;
        out_rd        = rd_q;
    end

    // Request and result registers. A flush drops everything that was captured.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mag_a   <= '0;
            mag_b   <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            rem_sel <= 1'b0;
            result  <= '0;
            rd_q    <= '0;
        end else if (accept) begin
            rd_q    <= in_rd;
            rem_sel <= in_op[1];
            q_neg   <= rs1_neg ^ rs2_neg;
            r_neg   <= rs1_neg;
            // Negating the most negative value yields itself, which is its correct unsigned magnitude.
            mag_a   <= rs1_neg ? -in_rs1 : in_rs1;
            mag_b   <= rs2_neg ? -in_rs2 : in_rs2;
            if (bypass)
                result <= bypass_res;
        end else if ((state == ST_WAIT) && core_done) begin
            result  <= rem_sel ? r_fix : q_fix;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl. Each scenario uses hand-computed expected values.
module tb_div_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [DW-1:0] in_rs1, in_rs2;
    logic [4:0]    in_rd;
    logic          flush;
    logic          core_start;
    logic [DW-1:0] core_dividend, core_divisor;
    logic          core_done;
    logic [DW-1:0] core_quotient, core_remainder;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [4:0]    out_rd;
    logic          busy;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_ctrl #(.DW(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_rd          (in_rd),
        .flush          (flush),
        .core_start     (core_start),
        .core_dividend  (core_dividend),
        .core_divisor   (core_divisor),
        .core_done      (core_done),
        .core_quotient  (core_quotient),
        .core_remainder (core_remainder),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rd         (out_rd),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle. On return the DUT has sampled it.
    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = rd;
        step();
        in_valid = 1'b0;
    endtask

    // Core-path transaction. The stub answers on the 5th WAIT cycle.
    task automatic run_core(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic [31:0] q,
                            input logic [31:0] r, input logic [31:0] edvd, input logic [31:0] edvs,
                            input logic [31:0] eres);
        do_req(op, a, b, rd);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_start"}, {31'd0, core_start}, 32'd1);
            chk({tag, "_dvd"}, core_dividend, edvd);
            chk({tag, "_dvs"}, core_divisor, edvs);
            chk({tag, "_nvld"}, {31'd0, out_valid}, 32'd0);
            step();
        end
        core_done      = 1'b1;
        core_quotient  = q;
        core_remainder = r;
        chk({tag, "_start_on_done"}, {31'd0, core_start}, 32'd1);
        step();
        core_done      = 1'b0;
        core_quotient  = '0;
        core_remainder = '0;
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, out_result, eres);
        chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
        chk({tag, "_start_off"}, {31'd0, core_start}, 32'd0);
        chk({tag, "_dvd_off"}, core_dividend, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rdy_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Bypass transaction. The result appears one cycle after acceptance, and the core is never started.
    task automatic run_bypass(input string tag, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd, input logic [31:0] eres);
        do_req(op, a, b, rd);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, out_result, eres);
        chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
        chk({tag, "_nostart"}, {31'd0, core_start}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_nostart2"}, {31'd0, core_start}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        flush = 1'b0; core_done = 1'b0; core_quotient = '0; core_remainder = '0; out_ready = 1'b0;

        // Reset state
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_core_start", {31'd0, core_start}, 32'd0);
        chk("rst_dividend", core_dividend, 32'd0);
        chk("rst_divisor", core_divisor, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step();

        // Core path with sign fix-up
        run_core("div_m7_2",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'd3, 32'd1, 32'd7, 32'd2, 32'hFFFF_FFFD);
        run_core("rem_m7_2",  OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'd3, 32'd1, 32'd7, 32'd2, 32'hFFFF_FFFF);
        run_core("remu_7_2",  OP_REMU, 32'd7, 32'd2, 5'd7, 32'd3, 32'd1, 32'd7, 32'd2, 32'd1);
        run_core("divu_big",  OP_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'h7FFF_FFFC, 32'd1,
                 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
        run_core("div_7_m2",  OP_DIV,  32'd7, 32'hFFFF_FFFE, 5'd9, 32'd3, 32'd1, 32'd7, 32'd2, 32'hFFFF_FFFD);
        run_core("rem_7_m2",  OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd10, 32'd3, 32'd1, 32'd7, 32'd2, 32'd1);
        // 0x80000000 / 0xFFFFFFFF as an unsigned op is not an overflow case, so it goes to the core.
        run_core("divu_min",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 32'h8000_0000,
                 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Divide by zero and signed overflow bypasses
        run_bypass("divu_z", OP_DIVU, 32'h1234_5678, 32'd0, 5'd12, 32'hFFFF_FFFF);
        run_bypass("rem_z",  OP_REM,  32'h1234_5678, 32'd0, 5'd13, 32'h1234_5678);
        run_bypass("div_z",  OP_DIV,  32'hFFFF_FFF9, 32'd0, 5'd14, 32'hFFFF_FFFF);
        run_bypass("rem_zn", OP_REM,  32'hFFFF_FFF9, 32'd0, 5'd15, 32'hFFFF_FFF9);
        run_bypass("div_ov", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000);
        run_bypass("rem_ov", OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0);

        // Flush two cycles into WAIT, followed by a stale core_done
        do_req(OP_DIV, 32'h8000_0000, 32'd2, 5'd9);
        chk("fl_min_mag", core_dividend, 32'h8000_0000);
        chk("fl_dvs", core_divisor, 32'd2);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_start", {31'd0, core_start}, 32'd0);
        chk("fl_dvd", core_dividend, 32'd0);
        chk("fl_busy", {31'd0, busy}, 32'd0);
        chk("fl_vld", {31'd0, out_valid}, 32'd0);
        core_done = 1'b1; core_quotient = 32'd5; core_remainder = 32'd3;
        step();
        core_done = 1'b0; core_quotient = '0; core_remainder = '0;
        chk("fl_stale_vld", {31'd0, out_valid}, 32'd0);
        chk("fl_stale_busy", {31'd0, busy}, 32'd0);
        step();
        chk("fl_stale_vld2", {31'd0, out_valid}, 32'd0);
        run_core("fl_next", OP_DIVU, 32'd100, 32'd7, 5'd20, 32'd14, 32'd2, 32'd100, 32'd7, 32'd14);

        // A flush in the same cycle as in_valid wins, so no request is accepted.
        in_valid = 1'b1; in_op = OP_DIVU; in_rs1 = 32'd5; in_rs2 = 32'd0; in_rd = 5'd1;
        flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flv_busy", {31'd0, busy}, 32'd0);
        chk("flv_vld", {31'd0, out_valid}, 32'd0);
        chk("flv_in_ready", {31'd0, in_ready}, 32'd1);

        // Hold DONE for 4 cycles while a competing request is pending.
        do_req(OP_REMU, 32'h0000_ABCD, 32'd0, 5'd17);
        in_valid = 1'b1; in_op = OP_DIVU; in_rs1 = 32'd9; in_rs2 = 32'd0; in_rd = 5'd3;
        for (int i = 0; i < 4; i++) begin
            chk("hold_vld", {31'd0, out_valid}, 32'd1);
            chk("hold_res", out_result, 32'h0000_ABCD);
            chk("hold_rd", {27'd0, out_rd}, 32'd17);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        chk("hold_last_res", out_result, 32'h0000_ABCD);
        step();
        out_ready = 1'b0;
        chk("hold_after_vld", {31'd0, out_valid}, 32'd0);
        chk("hold_after_rdy", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("hold_next_vld", {31'd0, out_valid}, 32'd1);
        chk("hold_next_res", out_result, 32'hFFFF_FFFF);
        chk("hold_next_rd", {27'd0, out_rd}, 32'd3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset mid-WAIT abandons the operation, so a later core_done is ignored.
        do_req(OP_DIV, 32'd100, 32'd7, 5'd12);
        step();
        rst = 1'b1;
        flush = 1'b1;
        step();
        rst = 1'b0;
        flush = 1'b0;
        chk("rw_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rw_start", {31'd0, core_start}, 32'd0);
        chk("rw_res", out_result, 32'd0);
        chk("rw_rd", {27'd0, out_rd}, 32'd0);
        core_done = 1'b1; core_quotient = 32'd14; core_remainder = 32'd2;
        step();
        core_done = 1'b0;
        chk("rw_stale_vld", {31'd0, out_valid}, 32'd0);
        chk("rw_stale_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter: DW, default 32, operand and result width.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 in_rs1, in_rs2  input  DW each  dividend and divisor (two's complement for DIV/REM).
REQ-008 in_rd  input  5  destination tag, returned unchanged.
REQ-009 flush  input  1  abort any in-flight operation.
REQ-010 core_start  output  1  level request to the normalize/iterate core; held while waiting.
REQ-011 core_dividend, core_divisor  output  DW each  unsigned magnitudes to the core.
REQ-012 core_done  input  1  single-cycle pulse: core_quotient/core_remainder are valid.
REQ-013 core_quotient, core_remainder  input  DW each  unsigned core results.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  consumer accepts result.
REQ-016 out_result  output  DW  final RISC-V M result.
REQ-017 out_rd  output  5  tag of the result.
REQ-018 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-021 On acceptance, the block SHALL register op, rd, sign flags, and magnitudes: |rs1| and |rs2| for DIV/REM, raw values for DIVU/REMU; |0x80000000| = 0x80000000.
REQ-022 If rs2==0, the block SHALL bypass the core and go IDLE->DONE: quotient = all ones, remainder = rs1 (raw), for signed and unsigned ops.
REQ-023 If op is DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF, the block SHALL bypass the core: quotient = 0x80000000, remainder = 0.
REQ-024 Otherwise the block SHALL go IDLE->WAIT, with core_start=1 from the cycle after acceptance until the cycle core_done is sampled high, inclusive.
REQ-025 core_dividend/core_divisor SHALL be stable for the whole period core_start=1, and 0 otherwise.
REQ-026 On core_done in WAIT, the block SHALL apply the sign fix-up: quotient negated iff signed op and sign(rs1)!=sign(rs2); remainder negated iff signed op and rs1 negative. It SHALL then register out_result (quotient for DIV/DIVU, remainder for REM/REMU) and enter DONE the next cycle.
REQ-027 core_done outside WAIT SHALL be ignored.
REQ-028 In DONE, out_valid=1, and out_result/out_rd SHALL be held stable until out_ready=1. Then the FSM enters IDLE the next cycle.
REQ-029 No new request SHALL be accepted in the same cycle a result is consumed; minimum spacing is one IDLE cycle.
REQ-030 Latency: a bypass case has out_valid in acceptance cycle +1. The core path has out_valid in the core_done cycle +1.
REQ-031 flush=1 in any state SHALL force IDLE on the next edge and drop core_start, out_valid, and the registered request. A core_done arriving after a flush SHALL be discarded.
REQ-032 flush and in_valid in the same IDLE cycle: flush wins and no request is accepted.
REQ-033 All arithmetic SHALL be DW-bit modulo two's complement, with no extra result width.

Reset
REQ-034 With rst=1 at an edge, the block SHALL set: state IDLE; in_ready=1 in the following cycle; core_start=0, core_dividend=0, core_divisor=0, out_valid=0, out_result=0, out_rd=0, busy=0.
REQ-035 rst SHALL take priority over flush and all handshakes. Reset mid-WAIT SHALL abandon the operation, and a later core_done SHALL be ignored.

Verification
REQ-036 DIV rs1=0xFFFFFFF9 (-7), rs2=2; core stub returns q=3, r=1 after 5 cycles. Required: core_dividend=7, core_divisor=2, out_result=0xFFFFFFFD (-3).
REQ-037 REM with the same operands. Required: out_result=0xFFFFFFFF (-1). REMU 7/2 gives out_result=1.
REQ-038 DIVU rs1=0x12345678, rs2=0. Required: core_start stays 0, out_valid one cycle after acceptance, out_result=0xFFFFFFFF. REM x/0 gives out_result=0x12345678.
REQ-039 DIV 0x80000000 / 0xFFFFFFFF. Required: out_result=0x80000000, and REM gives 0, with no core_start.
REQ-040 flush two cycles into WAIT, then core_done pulses one cycle later. Required: out_valid never rises, in_ready=1 the cycle after flush, and a new request completes correctly.
REQ-041 Hold out_ready=0 for 4 cycles in DONE. Required: out_valid, out_result and out_rd stay stable and in_ready stays 0 until the consume cycle +1.
